// File: rtl/cache_line_fill.sv
// cache_line_fill: critical-word-first cache line refill from a narrow external bus
module cache_line_fill #(
  parameter int BITS = 32,
  parameter int ADDRESS_BITS = 14,
  parameter int EXT_BITS = 8,
  parameter int LINE_WORDS = 4,
  parameter int EXT_WAIT = 2,
  localparam int BEATS = BITS / EXT_BITS,
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 0
) (
  input  logic                       CLK,
  input  logic                       RSTb,
  input  logic                       miss_req,
  input  logic [ADDRESS_BITS-1:0]    miss_addr,
  output logic                       busy,
  output logic [ADDRESS_BITS-1:0]    fill_addr,
  output logic [BITS-1:0]            fill_data,
  output logic                       fill_WRb,
  output logic                       crit_valid,
  output logic                       fill_done,
  output logic [ADDRESS_BITS+BW-1:0] ext_addr,
  input  logic [EXT_BITS-1:0]        ext_data_in,
  output logic                       ext_CEb,
  output logic                       ext_OEb
);
  localparam int AW = ADDRESS_BITS;
  localparam int EA = AW + BW;
  localparam int LW = $clog2(LINE_WORDS);
  localparam int BWW = (BW > 0) ? BW : 1;
  localparam int CW = (EXT_WAIT > 0) ? $clog2(EXT_WAIT + 1) : 1;

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, WRITE, DONE} state_t;

  state_t           state, state_nx;
  logic [AW-LW-1:0] base, base_nx;
  logic [LW-1:0]    ptr, ptr_nx;
  logic [LW-1:0]    words, words_nx;
  logic [BWW-1:0]   beat, beat_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             first, first_nx;
  logic [BITS-1:0]  asm_w, asm_nx;
  logic             busy_nx, wrb_nx, crit_nx, done_nx, ceb_nx;
  logic [AW-1:0]    fill_addr_nx;
  logic [BITS-1:0]  fill_data_nx;
  logic [EA-1:0]    ext_addr_nx;

  // Beat address: word address scaled by beats per word, plus the beat index.
  function automatic logic [EA-1:0] beat_addr(input logic [AW-LW-1:0] b, input logic [LW-1:0] p,
                                              input logic [BWW-1:0] t);
    return (EA'({b, p}) << BW) | EA'(t);
  endfunction

  assign ext_OEb = ext_CEb;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_nx = state;
    base_nx = base;
    ptr_nx = ptr;
    words_nx = words;
    beat_nx = beat;
    cnt_nx = cnt;
    first_nx = first;
    asm_nx = asm_w;
    busy_nx = busy;
    fill_addr_nx = fill_addr;
    fill_data_nx = fill_data;
    ext_addr_nx = ext_addr;
    wrb_nx = 1'b1;
    crit_nx = 1'b0;
    done_nx = 1'b0;
    ceb_nx = 1'b1;
    case (state)
      IDLE: begin
        busy_nx = miss_req;
        if (miss_req) begin
          state_nx = ADDR;
          base_nx = miss_addr[AW-1:LW];
          ptr_nx = miss_addr[LW-1:0];
          words_nx = '0;
          beat_nx = '0;
          first_nx = 1'b1;
          ext_addr_nx = beat_addr(miss_addr[AW-1:LW], miss_addr[LW-1:0], '0);
          ceb_nx = 1'b0;
        end
      end
      ADDR: begin
        state_nx = WAIT;
        cnt_nx = CW'(EXT_WAIT);
        ceb_nx = 1'b0;
      end
      WAIT: begin
        ceb_nx = 1'b0;
        if (cnt != '0) cnt_nx = cnt - CW'(1);
        else begin
          asm_nx[int'(beat)*EXT_BITS +: EXT_BITS] = ext_data_in;
          if (beat == BWW'(BEATS - 1)) begin
            state_nx = WRITE;
            ceb_nx = 1'b1;
            wrb_nx = 1'b0;
            crit_nx = first;
            fill_addr_nx = {base, ptr};
            fill_data_nx = asm_nx;
          end else begin
            state_nx = ADDR;
            beat_nx = beat + BWW'(1);
            ext_addr_nx = beat_addr(base, ptr, beat_nx);
          end
        end
      end
      WRITE: begin
        first_nx = 1'b0;
        if (words == LW'(LINE_WORDS - 1)) begin
          state_nx = DONE;
          done_nx = 1'b1;
        end else begin
          state_nx = ADDR;
          words_nx = words + LW'(1);
          ptr_nx = ptr + LW'(1);
          beat_nx = '0;
          ext_addr_nx = beat_addr(base, ptr_nx, '0);
          ceb_nx = 1'b0;
        end
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers; reset abandons any partial line immediately.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state <= IDLE;
      base <= '0;
      ptr <= '0;
      words <= '0;
      beat <= '0;
      cnt <= '0;
      first <= 1'b0;
      asm_w <= '0;
      busy <= 1'b0;
      fill_addr <= '0;
      fill_data <= '0;
      fill_WRb <= 1'b1;
      crit_valid <= 1'b0;
      fill_done <= 1'b0;
      ext_addr <= '0;
      ext_CEb <= 1'b1;
    end else begin
      state <= state_nx;
      base <= base_nx;
      ptr <= ptr_nx;
      words <= words_nx;
      beat <= beat_nx;
      cnt <= cnt_nx;
      first <= first_nx;
      asm_w <= asm_nx;
      busy <= busy_nx;
      fill_addr <= fill_addr_nx;
      fill_data <= fill_data_nx;
      fill_WRb <= wrb_nx;
      crit_valid <= crit_nx;
      fill_done <= done_nx;
      ext_addr <= ext_addr_nx;
      ext_CEb <= ceb_nx;
    end
  end
endmodule

// File: tb/tb_cache_line_fill.sv
// tb_cache_line_fill: directed self-checking bench for the cache line refill engine
module tb_cache_line_fill;
  logic CLK = 1'b0;
  logic RSTb = 1'b0;
  always #5 CLK = ~CLK;

  logic        miss_req, busy, fill_WRb, crit_valid, fill_done, ext_CEb, ext_OEb;
  logic [13:0] miss_addr, fill_addr;
  logic [31:0] fill_data;
  logic [15:0] ext_addr;
  logic [7:0]  ext_d;

  logic        miss_req4, busy4, fill_WRb4, crit4, done4, ext_CEb4, ext_OEb4;
  logic [13:0] miss_addr4, fill_addr4, ext_addr4;
  logic [31:0] fill_data4, ext_data4;

  cache_line_fill dut (
    .CLK(CLK), .RSTb(RSTb), .miss_req(miss_req), .miss_addr(miss_addr), .busy(busy),
    .fill_addr(fill_addr), .fill_data(fill_data), .fill_WRb(fill_WRb), .crit_valid(crit_valid),
    .fill_done(fill_done), .ext_addr(ext_addr), .ext_data_in(ext_d), .ext_CEb(ext_CEb),
    .ext_OEb(ext_OEb)
  );

  cache_line_fill #(.EXT_BITS(32), .EXT_WAIT(0)) dut4 (
    .CLK(CLK), .RSTb(RSTb), .miss_req(miss_req4), .miss_addr(miss_addr4), .busy(busy4),
    .fill_addr(fill_addr4), .fill_data(fill_data4), .fill_WRb(fill_WRb4), .crit_valid(crit4),
    .fill_done(done4), .ext_addr(ext_addr4), .ext_data_in(ext_data4), .ext_CEb(ext_CEb4),
    .ext_OEb(ext_OEb4)
  );

  assign ext_data4 = 32'hA500_0000 | {18'h0, ext_addr4};

  typedef struct {logic [13:0] a; logic [31:0] d; logic c; int t;} wr_t;
  wr_t wq[$];
  wr_t wq4[$];
  int  dq[$];
  int  dq4[$];
  int  cyc = 0, n_cmp = 0, n_err = 0, stray = 0, dbl = 0, a6 = 0, t0 = 0;
  bit  noise = 0;
  logic pw = 0, pd = 0, pc = 0;

  logic [31:0] d2 [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
  logic [13:0] a3 [4] = '{14'h3FFE, 14'h3FFF, 14'h3FFC, 14'h3FFD};
  logic [31:0] d3 [4] = '{32'hFBFAF9F8, 32'hFFFEFDFC, 32'hF3F2F1F0, 32'hF7F6F5F4};
  logic [13:0] a6e [4] = '{14'h0042, 14'h0043, 14'h0040, 14'h0041};
  logic [31:0] d6 [4] = '{32'h0B0A0908, 32'h0F0E0D0C, 32'h03020100, 32'h07060504};
  logic [13:0] a4 [4] = '{14'h1235, 14'h1236, 14'h1237, 14'h1234};

  always @(posedge CLK) cyc <= cyc + 1;

  // Record writes and done pulses, flag stretched pulses, and model the external memory.
  always @(negedge CLK) begin
    int p;
    if (!fill_WRb) wq.push_back(wr_t'{fill_addr, fill_data, crit_valid, cyc});
    if (fill_done) dq.push_back(cyc);
    if (!fill_WRb4) wq4.push_back(wr_t'{fill_addr4, fill_data4, crit4, cyc});
    if (done4) dq4.push_back(cyc);
    if (crit_valid && fill_WRb) stray++;
    if ((!fill_WRb && pw) || (fill_done && pd) || (crit_valid && pc)) dbl++;
    pw = !fill_WRb;
    pd = fill_done;
    pc = crit_valid;
    p = (cyc - a6) % 17;
    ext_d = (!noise || (cyc >= a6 && p < 16 && p % 4 == 3)) ? ext_addr[7:0] : 8'($urandom);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [13:0] a, output int t);
    @(negedge CLK);
    miss_req = 1'b1;
    miss_addr = a;
    @(negedge CLK);
    #1;
    t = cyc;
    miss_req = 1'b0;
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 300 && dq.size() < k; i++) @(negedge CLK);
    #1;
  endtask

  initial begin
    miss_req = 1'b0;
    miss_addr = '0;
    miss_req4 = 1'b0;
    miss_addr4 = '0;
    #12;
    chk("rst busy", busy, 0);
    chk("rst wrb", fill_WRb, 1);
    chk("rst crit", crit_valid, 0);
    chk("rst done", fill_done, 0);
    chk("rst ceb", ext_CEb, 1);
    chk("rst oeb", ext_OEb, 1);
    chk("rst faddr", fill_addr, 0);
    chk("rst fdata", fill_data, 0);
    chk("rst eaddr", ext_addr, 0);
    @(negedge CLK);
    RSTb = 1'b1;

    req(14'h0123, t0);
    @(negedge CLK);
    #1;
    chk("t1 ceb wait", ext_CEb, 0);
    chk("t1 busy wait", busy, 1);
    #2;
    RSTb = 1'b0;
    #1;
    chk("t1 ceb", ext_CEb, 1);
    chk("t1 oeb", ext_OEb, 1);
    chk("t1 wrb", fill_WRb, 1);
    chk("t1 busy", busy, 0);
    chk("t1 eaddr", ext_addr, 0);
    @(negedge CLK);
    RSTb = 1'b1;
    repeat (80) @(negedge CLK);
    #1;
    chk("t1 no writes", wq.size(), 0);
    chk("t1 no done", dq.size(), 0);
    chk("t1 idle", busy, 0);

    req(14'h0100, t0);
    chk("t2 eaddr0", ext_addr, 16'h0400);
    wait_done(1);
    chk("t2 nwr", wq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2 addr%0d", i), wq[i].a, 14'h0100 + 14'(i));
      chk($sformatf("t2 data%0d", i), wq[i].d, d2[i]);
    end
    chk("t2 crit", {wq[0].c, wq[1].c, wq[2].c, wq[3].c}, 4'b1000);
    chk("t2 first wr cycle", wq[0].t - t0 + 1, 17);
    chk("t2 done cycle", dq[0] - t0 + 1, 69);
    wq.delete();
    dq.delete();

    req(14'h3FFE, t0);
    chk("t3 eaddr0", ext_addr, 16'hFFF8);
    chk("t3 ceb", ext_CEb, 0);
    wait_done(1);
    chk("t3 nwr", wq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3 addr%0d", i), wq[i].a, a3[i]);
      chk($sformatf("t3 data%0d", i), wq[i].d, d3[i]);
    end
    chk("t3 crit", {wq[0].c, wq[1].c, wq[2].c, wq[3].c}, 4'b1000);
    wq.delete();
    dq.delete();

    noise = 1'b1;
    req(14'h0042, a6);
    wait_done(1);
    noise = 1'b0;
    chk("t6 nwr", wq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6 addr%0d", i), wq[i].a, a6e[i]);
      chk($sformatf("t6 data%0d", i), wq[i].d, d6[i]);
    end
    wq.delete();
    dq.delete();

    @(negedge CLK);
    miss_req = 1'b1;
    miss_addr = 14'h0200;
    @(negedge CLK);
    #1;
    t0 = cyc;
    for (int i = 0; i < 200; i++) begin
      if (fill_done) break;
      miss_addr = 14'h0300 + 14'(i * 5);
      @(negedge CLK);
      #1;
    end
    chk("t5 done1 seen", fill_done, 1);
    miss_addr = 14'h0504;
    @(negedge CLK);
    #1;
    chk("t5 gap busy", busy, 0);
    @(negedge CLK);
    #1;
    chk("t5 reaccept busy", busy, 1);
    chk("t5 reaccept eaddr", ext_addr, 16'h1410);
    miss_req = 1'b0;
    wait_done(2);
    chk("t5 nwr", wq.size(), 8);
    for (int i = 0; i < 4; i++) chk($sformatf("t5 addr%0d", i), wq[i].a, 14'h0200 + 14'(i));
    chk("t5 done1 cycle", dq[0] - t0 + 1, 69);
    chk("t5 fill2 addr", wq[4].a, 14'h0504);
    chk("t5 fill2 data", wq[4].d, 32'h13121110);
    chk("t5 fill2 crit", wq[4].c, 1);
    chk("t5 fill2 wr cycle", wq[4].t - t0 + 1, 87);
    chk("t5 done2 cycle", dq[1] - t0 + 1, 139);
    wq.delete();
    dq.delete();

    @(negedge CLK);
    miss_req4 = 1'b1;
    miss_addr4 = 14'h1235;
    @(negedge CLK);
    #1;
    t0 = cyc;
    miss_req4 = 1'b0;
    chk("t4 eaddr0", ext_addr4, 14'h1235);
    for (int i = 0; i < 100 && dq4.size() < 1; i++) @(negedge CLK);
    #1;
    chk("t4 ndone", dq4.size(), 1);
    chk("t4 nwr", wq4.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4 addr%0d", i), wq4[i].a, a4[i]);
      chk($sformatf("t4 data%0d", i), wq4[i].d, 32'hA500_0000 | {18'h0, a4[i]});
    end
    chk("t4 first wr cycle", wq4[0].t - t0 + 1, 3);
    chk("t4 last wr cycle", wq4[3].t - t0 + 1, 12);
    chk("t4 done cycle", dq4[0] - t0 + 1, 13);

    chk("stray crit", stray, 0);
    chk("stretched pulse", dbl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
